// File: rtl/arbitro_mux4_pkg.sv
// arbitro_mux4 shared definitions.
// States, defaults and the round-robin pick.
package arbitro_mux4_pkg;

  localparam int P_ENT_DEF  = 4;
  localparam int P_SLOT_DEF = 8;

  typedef enum logic {
    OCIOSO  = 1'b0,
    OCUPADO = 1'b1
  } state_e;

  // {found, index}: first set bit of r
  // scanning s, s+1, ... mod 4
  function automatic logic [2:0] rr_pick(
    input logic [3:0] r,
    input logic [1:0] s
  );
    logic [2:0] res;
    logic [1:0] k;
    res = '0;
    for (int i = 3; i >= 0; i--) begin
      k = s + 2'(i);
      if (r[k]) res = {1'b1, k};
    end
    return res;
  endfunction

  function automatic logic [3:0] onehot(
    input logic [1:0] idx
  );
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/arbitro_mux4_if.sv
// arbitro_mux4 request/grant/data bundle.
// master = requester side, slave = arbiter.
interface arbitro_mux4_if #(
  parameter int P_ENT = 4
);
  logic [3:0]       req;
  logic [P_ENT-1:0] ent0;
  logic [P_ENT-1:0] ent1;
  logic [P_ENT-1:0] ent2;
  logic [P_ENT-1:0] ent3;
  logic [3:0]       gnt;
  logic [1:0]       sel;
  logic [P_ENT-1:0] out;
  logic             valid;

  modport master (
    output req, ent0, ent1, ent2, ent3,
    input  gnt, sel, out, valid
  );

  modport slave (
    input  req, ent0, ent1, ent2, ent3,
    output gnt, sel, out, valid
  );
endinterface

// File: rtl/arbitro_mux4_mux.sv
// Shared 4x1 datapath multiplexer.
// Purely combinational; select by index.
module Mux4x1_4bits #(
  parameter int W = 4
) (
  input  logic [W-1:0] a0_i,
  input  logic [W-1:0] a1_i,
  input  logic [W-1:0] a2_i,
  input  logic [W-1:0] a3_i,
  input  logic [1:0]   s_i,
  output logic [W-1:0] y_o
);

  // select one of four inputs
  always_comb begin
    y_o = a0_i;
    unique case (s_i)
      2'd0: y_o = a0_i;
      2'd1: y_o = a1_i;
      2'd2: y_o = a2_i;
      2'd3: y_o = a3_i;
    endcase
  end

endmodule

// File: rtl/arbitro_mux4.sv
// Round-robin arbiter for the shared mux.
// Time-sliced grants, registered data out.
module arbitro_mux4
  import arbitro_mux4_pkg::*;
#(
  parameter int P_ENT  = P_ENT_DEF,
  parameter int P_SLOT = P_SLOT_DEF
) (
  input logic           clk,
  input logic           rst_n,
  arbitro_mux4_if.slave bus
);

  localparam int CW = $clog2(P_SLOT);

  state_e           state_q, state_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       sel_q, sel_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [P_ENT-1:0] out_q;
  logic             valid_q;
  logic [P_ENT-1:0] mux_y;

  logic [3:0] own_oh;
  logic [3:0] others;
  logic [3:0] cand;
  logic [1:0] nxt;
  logic       rel;
  logic [2:0] idle_pk;
  logic [2:0] rel_pk;

  assign own_oh  = onehot(sel_q);
  assign others  = bus.req & ~own_oh;
  assign cand    = (|others) ? others
                 : (bus.req & own_oh);
  assign nxt     = sel_q + 2'd1;
  assign rel     = !bus.req[sel_q] ||
                   (cnt_q == CW'(P_SLOT - 1));
  assign idle_pk = rr_pick(bus.req, ptr_q);
  assign rel_pk  = rr_pick(cand, nxt);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= OCIOSO;
    else        state_q <= state_d;
  end

  // next-state decision
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      OCIOSO:
        if (idle_pk[2]) state_d = OCUPADO;
      OCUPADO:
        if (rel && !rel_pk[2]) state_d = OCIOSO;
    endcase
  end

  // grant, select, slice and pointer updates
  always_comb begin
    gnt_d = gnt_q;
    sel_d = sel_q;
    cnt_d = cnt_q;
    ptr_d = ptr_q;
    unique case (state_q)
      OCIOSO: begin
        if (idle_pk[2]) begin
          gnt_d = onehot(idle_pk[1:0]);
          sel_d = idle_pk[1:0];
          cnt_d = '0;
        end
      end
      OCUPADO: begin
        if (!rel) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          ptr_d = nxt;
          cnt_d = '0;
          if (rel_pk[2]) begin
            gnt_d = onehot(rel_pk[1:0]);
            sel_d = rel_pk[1:0];
          end else begin
            gnt_d = '0;
          end
        end
      end
    endcase
  end

  // arbitration registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q <= '0;
      sel_q <= '0;
      cnt_q <= '0;
      ptr_q <= '0;
    end else begin
      gnt_q <= gnt_d;
      sel_q <= sel_d;
      cnt_q <= cnt_d;
      ptr_q <= ptr_d;
    end
  end

  Mux4x1_4bits #(
    .W (P_ENT)
  ) u_mux (
    .a0_i (bus.ent0),
    .a1_i (bus.ent1),
    .a2_i (bus.ent2),
    .a3_i (bus.ent3),
    .s_i  (sel_q),
    .y_o  (mux_y)
  );

  // registered data; holds while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= |gnt_q;
      if (|gnt_q) out_q <= mux_y;
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.sel   = sel_q;
  assign bus.out   = out_q;
  assign bus.valid = valid_q;

endmodule
